// File: rtl/eab_agu_if.sv
// Request, memory-read and result signals of the effective-address unit.
// The slave modport is the AGU; the master modport is its requester/memory side.
interface eab_agu_if #(
   parameter int WIDTH  = 16,
   parameter int OFF3_W = 11
);
   logic              req_valid;
   logic              req_ready;
   logic              sel_base;
   logic [1:0]        sel_off;
   logic              indirect;
   logic [WIDTH-1:0]  pc;
   logic [WIDTH-1:0]  ra;
   logic [OFF3_W-1:0] ir;
   logic              mem_req;
   logic [WIDTH-1:0]  mem_addr;
   logic              mem_ack;
   logic [WIDTH-1:0]  mem_data;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  ea;
   logic              ea_wrap;

   modport slave (
      input  req_valid, sel_base, sel_off, indirect, pc, ra, ir,
      input  mem_ack, mem_data, out_ready,
      output req_ready, mem_req, mem_addr, out_valid, ea, ea_wrap
   );

   modport master (
      output req_valid, sel_base, sel_off, indirect, pc, ra, ir,
      output mem_ack, mem_data, out_ready,
      input  req_ready, mem_req, mem_addr, out_valid, ea, ea_wrap
   );
endinterface

// File: rtl/eab_agu.sv
// LC-3 effective-address unit: base (PC/Ra) + sign-extended IR offset, registered
// behind valid/ready. Define EAB_AGU_INDIRECT_EN to add the indirect pointer fetch.
module eab_agu #(
   parameter int WIDTH  = 16,
   parameter int OFF1_W = 6,
   parameter int OFF2_W = 9,
   parameter int OFF3_W = 11
) (
   input logic      clk,
   input logic      reset,
   eab_agu_if.slave bus
);

`ifdef EAB_AGU_INDIRECT_EN
   typedef enum logic [1:0] {S_IDLE, S_MEM, S_DONE} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`endif

   function automatic logic signed [WIDTH-1:0] sext_off(input logic [OFF3_W-1:0] f,
                                                        input logic [1:0]        sel);
      logic signed [WIDTH-1:0] r;
      case (sel)
         2'b01:   r = {{(WIDTH-OFF1_W){f[OFF1_W-1]}}, f[OFF1_W-1:0]};
         2'b10:   r = {{(WIDTH-OFF2_W){f[OFF2_W-1]}}, f[OFF2_W-1:0]};
         2'b11:   r = {{(WIDTH-OFF3_W){f[OFF3_W-1]}}, f[OFF3_W-1:0]};
         default: r = '0;
      endcase
      return r;
   endfunction

   state_t                  state_q, state_d;
   logic [WIDTH-1:0]        ea_q, ea_d;
   logic                    ea_wrap_q, ea_wrap_d;
   logic [WIDTH-1:0]        base;
   logic signed [WIDTH-1:0] off;
   logic [WIDTH:0]          sum_full;
   logic                    indirect_eff;
   logic                    accept;
   logic                    req_ready_c;
   logic                    out_valid_c;
   logic                    mem_req_c;

`ifdef EAB_AGU_INDIRECT_EN
   logic [WIDTH-1:0]        mem_addr_q, mem_addr_d;
   assign indirect_eff = bus.indirect;
`else
   logic                    unused_mem_inputs;
   assign indirect_eff      = 1'b0;
   assign unused_mem_inputs = ^{bus.indirect, bus.mem_ack, bus.mem_data};
`endif

   assign base     = bus.sel_base ? bus.ra : bus.pc;
   assign off      = sext_off(bus.ir, bus.sel_off);
   assign sum_full = {1'b0, base} + {1'b0, off};

   always_comb begin
      state_d     = state_q;
      ea_d        = ea_q;
      ea_wrap_d   = ea_wrap_q;
      accept      = 1'b0;
      req_ready_c = 1'b0;
      out_valid_c = 1'b0;
      mem_req_c   = 1'b0;
`ifdef EAB_AGU_INDIRECT_EN
      mem_addr_d  = mem_addr_q;
`endif

      case (state_q)
         S_IDLE: begin
            req_ready_c = 1'b1;
            accept      = bus.req_valid;
         end
`ifdef EAB_AGU_INDIRECT_EN
         S_MEM: begin
            mem_req_c = 1'b1;
            if (bus.mem_ack) begin
               ea_d    = bus.mem_data;
               state_d = S_DONE;
            end
         end
`endif
         S_DONE: begin
            out_valid_c = 1'b1;
            req_ready_c = bus.out_ready;
            if (bus.out_ready) begin
               state_d = S_IDLE;
               accept  = bus.req_valid;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         ea_d      = sum_full[WIDTH-1:0];
         ea_wrap_d = sum_full[WIDTH];
`ifdef EAB_AGU_INDIRECT_EN
         mem_addr_d = sum_full[WIDTH-1:0];
`endif
         state_d   = indirect_eff ? state_t'(2'd1) : S_DONE;
      end

      // Handshake outputs are forced low for the whole time reset is asserted.
      if (reset) begin
         req_ready_c = 1'b0;
         out_valid_c = 1'b0;
         mem_req_c   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         ea_q      <= '0;
         ea_wrap_q <= 1'b0;
`ifdef EAB_AGU_INDIRECT_EN
         mem_addr_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         ea_q      <= ea_d;
         ea_wrap_q <= ea_wrap_d;
`ifdef EAB_AGU_INDIRECT_EN
         mem_addr_q <= mem_addr_d;
`endif
      end
   end

   assign bus.req_ready = req_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.mem_req   = mem_req_c;
   assign bus.ea        = ea_q;
   assign bus.ea_wrap   = ea_wrap_q;
`ifdef EAB_AGU_INDIRECT_EN
   assign bus.mem_addr  = mem_addr_q;
`else
   assign bus.mem_addr  = '0;
`endif

endmodule

// File: tb/tb_eab_agu.sv
// Directed bench for eab_agu with hand-computed expectations; follows
// EAB_AGU_INDIRECT_EN to select the indirect or direct expectations.
module tb_eab_agu;
   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;

   eab_agu_if bus ();

   eab_agu u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset         = 1'b1;
      bus.req_valid = 1'b0;
      bus.sel_base  = 1'b0;
      bus.sel_off   = 2'b00;
      bus.indirect  = 1'b0;
      bus.pc        = '0;
      bus.ra        = '0;
      bus.ir        = '0;
      bus.mem_ack   = 1'b0;
      bus.mem_data  = '0;
      bus.out_ready = 1'b0;

      cyc();
      cyc();
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_mem_req",   32'(bus.mem_req),   32'd0);
      chk("rst_ea",        32'(bus.ea),        32'h0);
      chk("rst_ea_wrap",   32'(bus.ea_wrap),   32'd0);
      chk("rst_mem_addr",  32'(bus.mem_addr),  32'h0);
      reset = 1'b0;
      #1;
      chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

      // pc + sext9(0x1FF): 0x3000 - 1 with carry out
      bus.pc = 16'h3000; bus.sel_base = 1'b0; bus.sel_off = 2'b10; bus.ir = 11'h1FF;
      bus.req_valid = 1'b1;
      cyc();
      bus.req_valid = 1'b0;
      #1;
      chk("neg_out_valid", 32'(bus.out_valid), 32'd1);
      chk("neg_ea",        32'(bus.ea),        32'h2FFF);
      chk("neg_wrap",      32'(bus.ea_wrap),   32'd1);
      chk("neg_req_ready", 32'(bus.req_ready), 32'd0);
      bus.out_ready = 1'b1;
      #1;
      chk("neg_req_ready_or", 32'(bus.req_ready), 32'd1);
      cyc();
      chk("neg_idle_valid", 32'(bus.out_valid), 32'd0);

      // ra + sext6(0x1F), followed back-to-back by a zero-offset pc request
      bus.ra = 16'h4000; bus.sel_base = 1'b1; bus.sel_off = 2'b01; bus.ir = 11'h01F;
      bus.req_valid = 1'b1;
      cyc();
      chk("ra_out_valid", 32'(bus.out_valid), 32'd1);
      chk("ra_ea",        32'(bus.ea),        32'h401F);
      chk("ra_wrap",      32'(bus.ea_wrap),   32'd0);
      bus.pc = 16'h1234; bus.sel_base = 1'b0; bus.sel_off = 2'b00; bus.ir = 11'h7FF;
      cyc();
      bus.req_valid = 1'b0;
      chk("zero_out_valid", 32'(bus.out_valid), 32'd1);
      chk("zero_ea",        32'(bus.ea),        32'h1234);
      chk("zero_wrap",      32'(bus.ea_wrap),   32'd0);
      cyc();
      chk("zero_idle_valid", 32'(bus.out_valid), 32'd0);

      // Indirect request: pc + sext11(0x010) = 0x3010
      bus.pc = 16'h3000; bus.sel_base = 1'b0; bus.sel_off = 2'b11; bus.ir = 11'h010;
      bus.indirect = 1'b1; bus.req_valid = 1'b1;
      cyc();
      bus.req_valid = 1'b0; bus.indirect = 1'b0;
`ifdef EAB_AGU_INDIRECT_EN
      chk("ind_mem_req_c1",  32'(bus.mem_req),   32'd1);
      chk("ind_mem_addr",    32'(bus.mem_addr),  32'h3010);
      chk("ind_no_valid_c1", 32'(bus.out_valid), 32'd0);
      cyc();
      chk("ind_mem_req_c2",  32'(bus.mem_req),   32'd1);
      cyc();
      chk("ind_mem_req_c3",  32'(bus.mem_req),   32'd1);
      chk("ind_mem_addr_c3", 32'(bus.mem_addr),  32'h3010);
      bus.mem_ack = 1'b1; bus.mem_data = 16'hBEEF;
      cyc();
      bus.mem_ack = 1'b0;
      chk("ind_out_valid", 32'(bus.out_valid), 32'd1);
      chk("ind_ea",        32'(bus.ea),        32'hBEEF);
      chk("ind_wrap",      32'(bus.ea_wrap),   32'd0);
      chk("ind_mem_req_d", 32'(bus.mem_req),   32'd0);
      cyc();
      bus.mem_ack = 1'b1; bus.mem_data = 16'h5555;
      cyc();
      bus.mem_ack = 1'b0;
      chk("stray_ack_valid", 32'(bus.out_valid), 32'd0);
      chk("stray_ack_ea",    32'(bus.ea),        32'hBEEF);
`else
      chk("ind_off_out_valid", 32'(bus.out_valid), 32'd1);
      chk("ind_off_ea",        32'(bus.ea),        32'h3010);
      chk("ind_off_mem_req",   32'(bus.mem_req),   32'd0);
      chk("ind_off_mem_addr",  32'(bus.mem_addr),  32'h0);
      cyc();
      bus.mem_ack = 1'b1; bus.mem_data = 16'h5555;
      cyc();
      bus.mem_ack = 1'b0;
      chk("stray_ack_valid", 32'(bus.out_valid), 32'd0);
      chk("stray_ack_ea",    32'(bus.ea),        32'h3010);
      chk("stray_mem_req",   32'(bus.mem_req),   32'd0);
`endif

      // Backpressure: ra + sext11(0x7FF) = 0x00FF with carry, held 5 cycles
      bus.out_ready = 1'b0;
      bus.ra = 16'h0100; bus.sel_base = 1'b1; bus.sel_off = 2'b11; bus.ir = 11'h7FF;
      bus.req_valid = 1'b1;
      cyc();
      // next request pending: pc + sext6(0x20) = 0x0ABC - 32 = 0x0A9C with carry
      bus.pc = 16'h0ABC; bus.sel_base = 1'b0; bus.sel_off = 2'b01; bus.ir = 11'h020;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_ea",        32'(bus.ea),        32'h00FF);
         chk("bp_wrap",      32'(bus.ea_wrap),   32'd1);
         chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
         cyc();
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(bus.req_ready), 32'd1);
      cyc();
      bus.req_valid = 1'b0;
      chk("b2b_out_valid", 32'(bus.out_valid), 32'd1);
      chk("b2b_ea",        32'(bus.ea),        32'h0A9C);
      chk("b2b_wrap",      32'(bus.ea_wrap),   32'd1);
      cyc();
      chk("b2b_idle_valid", 32'(bus.out_valid), 32'd0);

`ifdef EAB_AGU_INDIRECT_EN
      // Reset while waiting on memory; a late ack must not produce a result
      bus.pc = 16'h3000; bus.sel_base = 1'b0; bus.sel_off = 2'b11; bus.ir = 11'h010;
      bus.indirect = 1'b1; bus.req_valid = 1'b1;
      cyc();
      bus.req_valid = 1'b0; bus.indirect = 1'b0;
      chk("rmem_mem_req_pre", 32'(bus.mem_req), 32'd1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      #1;
      chk("rmem_mem_req_post", 32'(bus.mem_req), 32'd0);
      chk("rmem_ea",           32'(bus.ea),      32'h0);
      cyc();
      bus.mem_ack = 1'b1; bus.mem_data = 16'hDEAD;
      cyc();
      bus.mem_ack = 1'b0;
      chk("rmem_late_valid", 32'(bus.out_valid), 32'd0);
      chk("rmem_late_ea",    32'(bus.ea),        32'h0);
      chk("rmem_late_req",   32'(bus.mem_req),   32'd0);
`endif

      // Reset while a result is pending discards it
      bus.out_ready = 1'b0;
      bus.pc = 16'h1234; bus.sel_base = 1'b0; bus.sel_off = 2'b00;
      bus.req_valid = 1'b1;
      cyc();
      bus.req_valid = 1'b0;
      chk("rdone_pre_valid", 32'(bus.out_valid), 32'd1);
      reset = 1'b1;
      #1;
      chk("rdone_hi_valid", 32'(bus.out_valid), 32'd0);
      chk("rdone_hi_ready", 32'(bus.req_ready), 32'd0);
      cyc();
      reset = 1'b0;
      #1;
      chk("rdone_valid", 32'(bus.out_valid), 32'd0);
      chk("rdone_ea",    32'(bus.ea),        32'h0);
      chk("rdone_ready", 32'(bus.req_ready), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
